// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op codes, classification struct and helpers for the
// floating-point compare/select unit (fcmp_pipe, fcmp_core).
package fpu_pkg;

    // Default IEEE single-precision field widths.
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // Widest operand the canonical-NaN helper can build.
    localparam int FP_MAX_W = 128;

    // Operation codes; encodings 3'b101..3'b111 are illegal.
    typedef enum logic [2:0] {
        OP_FEQ  = 3'b000,
        OP_FLT  = 3'b001,
        OP_FLE  = 3'b010,
        OP_FMIN = 3'b011,
        OP_FMAX = 3'b100
    } fcmp_op_e;

    // Per-operand classification produced by fcmp_core.
    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_nan;
    } fcmp_class_t;

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    // Callers truncate the result to 1+exp_w+man_w bits.
    function automatic logic [FP_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        canonical_nan = (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// fcmp_core: purely combinational operand classification plus unsigned
// magnitude compare (exponent first, then mantissa) for fcmp_pipe.
// NaN detection is only active when FCMP_NAN_EN is defined; otherwise
// is_nan is constant 0 and NaN patterns are ordinary numbers.
module fcmp_core
    import fpu_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output fcmp_class_t  class_x,
    output fcmp_class_t  class_y,
    output logic         abs_lt,
    output logic         abs_eq
);

    logic [EXP_W-1:0] exp_x, exp_y;
    logic [MAN_W-1:0] man_x, man_y;

    assign exp_x = x[W-2 -: EXP_W];
    assign exp_y = y[W-2 -: EXP_W];
    assign man_x = x[MAN_W-1:0];
    assign man_y = y[MAN_W-1:0];

    // Sign, zero and (optionally) NaN flags of one operand.
    function automatic fcmp_class_t classify(input logic [W-1:0] v);
        fcmp_class_t c;
        c.sign    = v[W-1];
        c.is_zero = (v[W-2:0] == '0);
`ifdef FCMP_NAN_EN
        c.is_nan  = (&v[W-2 -: EXP_W]) & (|v[MAN_W-1:0]);
`else
        c.is_nan  = 1'b0;
`endif
        return c;
    endfunction

    assign class_x = classify(x);
    assign class_y = classify(y);

    // Magnitude ordering ignores the sign bit entirely.
    logic exp_lt, exp_eq, man_lt, man_eq;

    always_comb begin
        exp_lt = (exp_x < exp_y);
        exp_eq = (exp_x == exp_y);
        man_lt = (man_x < man_y);
        man_eq = (man_x == man_y);
        abs_lt = exp_lt | (exp_eq & man_lt);
        abs_eq = exp_eq & man_eq;
    end

endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined FEQ/FLT/FLE/FMIN/FMAX unit with valid/ready on both
// sides and a tag carried alongside each operation.
//   STAGES=2: stage 0 registers the operands with classify/magnitude results,
//             the output stage combines signs, selects and registers.
//   STAGES=1: classify, compare and select feed the output register directly.
// Optional build macro: FCMP_NAN_EN (IEEE-style NaN handling and out_nan).
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MAN_W  = FP_MAN_W,
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             out_nan
);

    generate
        if (XLEN < W) begin : g_bad_xlen
            $error("fcmp_pipe: XLEN must be at least 1+EXP_W+MAN_W");
        end
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("fcmp_pipe: STAGES must be 1 or 2");
        end
    endgenerate

`ifdef FCMP_NAN_EN
    localparam logic [W-1:0] CNAN = W'(canonical_nan(EXP_W, MAN_W));
`endif

    // One operation plus everything the select logic needs about it.
    typedef struct packed {
        logic [2:0]       op;
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
        fcmp_class_t      cx;
        fcmp_class_t      cy;
        logic             abs_lt;
        logic             abs_eq;
    } entry_t;

    entry_t      in_entry;
    entry_t      sel_entry;
    logic        sel_valid;
    logic        out_free;
    fcmp_class_t in_cx, in_cy;
    logic        in_abs_lt, in_abs_eq;

    fcmp_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .x       (in_x),
        .y       (in_y),
        .class_x (in_cx),
        .class_y (in_cy),
        .abs_lt  (in_abs_lt),
        .abs_eq  (in_abs_eq)
    );

    assign in_entry = '{op: in_op, x: in_x, y: in_y, tag: in_tag,
                        cx: in_cx, cy: in_cy, abs_lt: in_abs_lt, abs_eq: in_abs_eq};

    // The output slot can take a new result when empty or draining now.
    assign out_free = ~out_valid | out_ready;

    generate
        if (STAGES == 2) begin : g_two_stage
            logic   s0_valid;
            entry_t s0_entry;

            // Stage-0 occupancy: refill whenever the slot is empty or moving on.
            // NOTE: state is written with <= so every register samples the
            // pre-edge values, independent of block ordering in simulation.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s0_valid <= 1'b0;
                end else if (in_ready) begin
                    s0_valid <= in_valid;
                end
            end

            // Stage-0 payload capture on each accepted operation.
            // NOTE: payload needs no reset; s0_valid alone says whether it
            // holds anything, and leaving it unreset keeps it plain flops.
            always_ff @(posedge clk) begin
                if (in_valid && in_ready) begin
                    s0_entry <= in_entry;
                end
            end

            assign in_ready  = ~s0_valid | out_free;
            assign sel_valid = s0_valid;
            assign sel_entry = s0_entry;
        end else begin : g_one_stage
            assign in_ready  = out_free;
            assign sel_valid = in_valid;
            assign sel_entry = in_entry;
        end
    endgenerate

    // Result select: sign combination, zero rule, optional NaN rules, op decode.
    logic            both_zero, any_nan, is_eq, x_lt_y, y_lt_x;
    logic [W-1:0]    min_val, max_val;
    logic [XLEN-1:0] res_data;
    logic            res_illegal, res_nan;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        res_data    = '0;
        res_illegal = 1'b0;
        both_zero   = sel_entry.cx.is_zero & sel_entry.cy.is_zero;
        any_nan     = sel_entry.cx.is_nan | sel_entry.cy.is_nan;
        is_eq       = (sel_entry.x == sel_entry.y) | both_zero;

        case ({sel_entry.cx.sign, sel_entry.cy.sign})
            2'b10: begin
                x_lt_y = ~both_zero;
                y_lt_x = 1'b0;
            end
            2'b01: begin
                x_lt_y = 1'b0;
                y_lt_x = ~both_zero;
            end
            2'b00: begin
                x_lt_y = sel_entry.abs_lt;
                y_lt_x = ~sel_entry.abs_lt & ~sel_entry.abs_eq;
            end
            default: begin
                x_lt_y = ~sel_entry.abs_lt & ~sel_entry.abs_eq;
                y_lt_x = sel_entry.abs_lt;
            end
        endcase

        // -0 is the minimum of a zero pair, +0 the maximum; ties return x.
        if (both_zero) begin
            min_val = sel_entry.cx.sign ? sel_entry.x : sel_entry.y;
            max_val = sel_entry.cx.sign ? sel_entry.y : sel_entry.x;
        end else begin
            min_val = y_lt_x ? sel_entry.y : sel_entry.x;
            max_val = x_lt_y ? sel_entry.y : sel_entry.x;
        end

`ifdef FCMP_NAN_EN
        // A single NaN loses to the other operand; two NaNs give the canonical one.
        if (sel_entry.cx.is_nan && sel_entry.cy.is_nan) begin
            min_val = CNAN;
            max_val = CNAN;
        end else if (sel_entry.cx.is_nan) begin
            min_val = sel_entry.y;
            max_val = sel_entry.y;
        end else if (sel_entry.cy.is_nan) begin
            min_val = sel_entry.x;
            max_val = sel_entry.x;
        end
        if (any_nan) begin
            is_eq  = 1'b0;
            x_lt_y = 1'b0;
        end
`endif

        case (sel_entry.op)
            OP_FEQ:  res_data = XLEN'(is_eq);
            OP_FLT:  res_data = XLEN'(x_lt_y);
            OP_FLE:  res_data = XLEN'(x_lt_y | is_eq);
            OP_FMIN: res_data = XLEN'(min_val);
            OP_FMAX: res_data = XLEN'(max_val);
            default: res_illegal = 1'b1;
        endcase

        // Constant 0 unless NaN detection is built in.
        res_nan = any_nan;
    end

    // Output stage: load when the slot is free, otherwise hold for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            out_nan     <= 1'b0;
        end else if (out_free) begin
            out_valid <= sel_valid;
            if (sel_valid) begin
                out_data    <= res_data;
                out_tag     <= sel_entry.tag;
                out_illegal <= res_illegal;
                out_nan     <= res_nan;
            end
        end
    end

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed self-checking bench for fcmp_pipe at default widths.
// A sign/magnitude-to-integer ordering model predicts every result; a monitor
// compares the DUT against it on every cycle the output is valid.
module tb_fcmp_pipe;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    localparam logic [2:0] FEQ = 3'd0, FLT = 3'd1, FLE = 3'd2, FMIN = 3'd3, FMAX = 3'd4;
    localparam logic [2:0] ILL = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [W-1:0]     in_x = '0;
    logic [W-1:0]     in_y = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             out_nan;

    fcmp_pipe #(
        .EXP_W (EXP_W), .MAN_W (MAN_W), .XLEN (XLEN), .STAGES (STAGES), .TAG_W (TAG_W)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_op (in_op),
        .in_x (in_x), .in_y (in_y), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_tag (out_tag), .out_illegal (out_illegal), .out_nan (out_nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             illegal;
        logic             nan;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    logic saw_ready_low = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Spec model: map sign/magnitude onto a signed integer order key, so +0
    // and -0 share key 0 and every other pattern gets a unique key.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   r;
        longint mx, my, kx, ky;
        logic   lt, gt, eq, zz;
        mx = longint'(x[W-2:0]);
        my = longint'(y[W-2:0]);
        kx = x[W-1] ? -mx : mx;
        ky = y[W-1] ? -my : my;
        lt = (kx < ky);
        gt = (ky < kx);
        eq = (kx == ky);
        zz = (mx == 0) && (my == 0);
        r.data = '0; r.tag = '0; r.illegal = 1'b0; r.nan = 1'b0;
        case (op)
            FEQ:  r.data = XLEN'(eq);
            FLT:  r.data = XLEN'(lt);
            FLE:  r.data = XLEN'(lt | eq);
            FMIN: r.data = XLEN'(zz ? (x[W-1] ? x : y) : (gt ? y : x));
            FMAX: r.data = XLEN'(zz ? (x[W-1] ? y : x) : (lt ? y : x));
            default: r.illegal = 1'b1;
        endcase
`ifdef FCMP_NAN_EN
        begin
            logic nx, ny;
            nx = (x[W-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
            ny = (y[W-2 -: EXP_W] == '1) && (y[MAN_W-1:0] != '0);
            if (nx || ny) begin
                r.nan = 1'b1;
                if (op == FEQ || op == FLT || op == FLE) r.data = '0;
                else if (op == FMIN || op == FMAX)
                    r.data = XLEN'((nx && ny) ? 32'h7FC00000 : (nx ? y : x));
            end
        end
`endif
        return r;
    endfunction

    // Monitor: away from the active edge, check in_ready occupancy rule, compare
    // the presented result with the oldest expectation, and track transfers
    // that will happen at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, (sb.size() < STAGES) || out_ready);
            if (!in_ready) saw_ready_low = 1'b1;
            if (sb.size() == 0) begin
                check("no_entry_out_valid", out_valid, 0);
            end else if (out_valid) begin
                check("out_data", out_data, sb[0].data);
                check("out_tag", out_tag, sb[0].tag);
                check("out_illegal", out_illegal, sb[0].illegal);
                check("out_nan", out_nan, sb[0].nan);
                if (out_ready) begin
                    void'(sb.pop_front());
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(in_op, in_x, in_y);
                e.tag = in_tag;
                sb.push_back(e);
            end
        end
    end

    // Offer one operation and hold it until accepted (bounded).
    task automatic push(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [TAG_W-1:0] tag);
        int n;
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] want;
        logic        want_ill;
        logic        want_nan;
    } vec_t;

    vec_t vecs[15];

    // Literal expectations that pin the model and the DUT at key points.
    task automatic pin_model(input string name, input vec_t v);
        exp_t m;
        m = model(v.op, v.x, v.y);
        check({name, "_data"}, m.data, v.want);
        check({name, "_ill"}, m.illegal, v.want_ill);
        check({name, "_nan"}, m.nan, v.want_nan);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int   start;
        int   stale;
        int   n;
        vec_t v;
`ifdef FCMP_NAN_EN
        localparam logic NAN_ON = 1'b1;
`else
        localparam logic NAN_ON = 1'b0;
`endif
        vecs[0]  = '{FLT,  32'hBF800000, 32'hC0000000, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{FLT,  32'hC0000000, 32'hBF800000, 32'h1,        1'b0, 1'b0};
        vecs[2]  = '{FEQ,  32'h80000000, 32'h00000000, 32'h1,        1'b0, 1'b0};
        vecs[3]  = '{FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
        vecs[4]  = '{FMAX, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{ILL,  32'h3F800000, 32'h40000000, 32'h0,        1'b1, 1'b0};
        vecs[6]  = '{FEQ,  32'h7FC00000, 32'h7FC00000, {31'h0, ~NAN_ON}, 1'b0, NAN_ON};
        vecs[7]  = '{FMIN, 32'h7FC00001, 32'h3F800000, 32'h3F800000, 1'b0, NAN_ON};
        vecs[8]  = '{FLT,  32'h00000000, 32'h80000000, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{FLE,  32'h00000000, 32'h80000000, 32'h1,        1'b0, 1'b0};
        vecs[10] = '{FMAX, 32'h3F800000, 32'hBF800000, 32'h3F800000, 1'b0, 1'b0};
        vecs[11] = '{FMIN, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0};
        vecs[12] = '{FEQ,  32'h3F800000, 32'h3F800001, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{FLT,  32'h80000000, 32'h00000000, 32'h0,        1'b0, 1'b0};
        vecs[14] = '{FMIN, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};

        // Reset state.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_out_nan", out_nan, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // FLE 1.0 <= 2.0 with tag 5: result exactly STAGES cycles after accept.
        v = '{FLE, 32'h3F800000, 32'h40000000, 32'h1, 1'b0, 1'b0};
        pin_model("fle_pin", v);
        push(FLE, 32'h3F800000, 32'h40000000, 5'd5);
        for (int i = 1; i <= STAGES; i++) begin
            @(negedge clk);
            check("latency_out_valid", out_valid, (i == STAGES));
        end
        check("fle_out_data", out_data, 32'h1);
        check("fle_out_tag", out_tag, 5);
        drain();

        // Directed table, back to back with the consumer always ready.
        foreach (vecs[i]) begin
            pin_model($sformatf("vec%0d_pin", i), vecs[i]);
            push(vecs[i].op, vecs[i].x, vecs[i].y, TAG_W'(i));
        end
        drain();

        // Eight back-to-back ops with a three-cycle consumer stall mid-stream.
        saw_ready_low = 1'b0;
        start = delivered;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push(3'(i % 5), 32'h3F800000 + 32'(i << 20), 32'hBFC00000 ^ 32'(i << 31),
                         TAG_W'(16 + i));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_in_ready_dropped", saw_ready_low, 1);
        check("stall_delivered", delivered - start, 8);

        // Asynchronous reset with both stages holding operations.
        out_ready = 1'b0;
        push(FLT, 32'hC0000000, 32'hBF800000, 5'd1);
        push(FEQ, 32'h3F800000, 32'h3F800000, 5'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_after_rst", stale, 0);

        // A fresh operation after reset completes normally.
        push(FMAX, 32'h3F800000, 32'hBF800000, 5'd9);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_out_data", out_data, 32'h3F800000);
        check("post_rst_out_tag", out_tag, 9);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
Parametrised, pipelined floating-point compare/select unit for the FPU. It is the successor to the single-purpose combinational less-or-equal compare. It executes FEQ, FLT, FLE, FMIN and FMAX on IEEE-style operands of configurable exponent/mantissa width. Valid/ready handshakes are used on both sides, and a destination tag travels with each operation so the issue stage can route results back to the register file.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa field width; operand width W = 1+EXP_W+MAN_W
XLEN, 32, result width; XLEN >= W required (elaboration error otherwise)
STAGES, 2, pipeline depth, legal values 1 or 2 (elaboration error otherwise)
TAG_W, 5, width of sideband tag

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation offered
in_ready  output  1  unit accepts this cycle
in_op  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others illegal
in_x  input  W  operand x
in_y  input  W  operand y
in_tag  input  TAG_W  sideband, returned unchanged
out_valid  output  1  result available
out_ready  input  1  consumer accepts
out_data  output  XLEN  result
out_tag  output  TAG_W  tag of this result
out_illegal  output  1  op code was illegal (out_data = 0)
out_nan  output  1  an operand was NaN (FCMP_NAN_EN only, else constant 0)

Behaviour:
- Reset (async assert, sync-released by the system): all stage valids clear; out_valid, out_data, out_tag, out_illegal and out_nan are all 0. Operations in flight are discarded, not replayed.
- Transfer occurs when valid&ready on a side. in_ready = ~stage0_valid | stage0_advances. Each stage advances when its downstream slot is empty or draining in the same cycle. Full throughput is one op per cycle under continuous out_ready.
- Latency from in accept to out_valid is exactly STAGES cycles with no backpressure.
- STAGES=2: stage 0 registers op/x/y/tag and computes classify plus magnitude compare. The magnitude compare is unsigned exponent-lt, exponent-eq and mantissa-lt, giving abs_lt and abs_eq. Stage 1 combines signs, selects the result and registers the outputs.
- STAGES=1: the same logic is fully combinational into the output register.
- Stall: while out_valid & ~out_ready, all outputs hold stable and no stage overwrites an unconsumed entry. With both stages full, in_ready = 0.
- Zero rule (always on): +0 and -0 (exponent and mantissa all zero) compare equal.
  - FEQ(+0,-0) = 1, FLT = 0, FLE = 1.
- Compare results are zero-extended 1-bit values in out_data[0]:
  - FEQ: bit-equal, or both zero.
  - FLT:
    - x negative, y positive: true unless both are zero.
    - Both positive: abs_lt.
    - Both negative: ~abs_lt & ~abs_eq.
  - FLE: FLT | FEQ.
- FMIN/FMAX return the selected operand zero-extended to XLEN.
  - Equal operands: FMIN returns x; FMAX returns x.
  - Zero tie: FMIN(+0,-0) = -0 and FMAX = +0, regardless of argument order.
- Illegal op: out_data = 0, out_illegal = 1; the handshake and latency are unchanged.
- Simultaneous in accept and out drain with the pipe full: both transfers happen; the pipe stays full.

Optional Feature:
FCMP_NAN_EN.
- Defined: NaN = exponent all ones and mantissa nonzero.
  - FEQ/FLT/FLE with any NaN operand return 0.
  - FMIN/FMAX with one NaN operand return the other operand.
  - FMIN/FMAX with both operands NaN return the canonical NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0 (0x7FC00000 at default widths).
  - out_nan = 1 whenever either operand is NaN.
- Undefined: NaNs are ordinary bit patterns under the sign/magnitude rules, and out_nan is tied 0.

Decomposition:
- Package fpu_pkg holds:
  - fcmp_op_e enum (3-bit op codes).
  - Default EXP_W/MAN_W constants.
  - A canonical-NaN function parametrised by widths.
  - A classify struct (sign, is_zero, is_nan).
- One sub-module, fcmp_core: purely combinational classify plus magnitude compare, instantiated in stage 0. fcmp_pipe owns the registers, handshake and result select.

Test Plan:
- FLE x=0x3F800000 (1.0), y=0x40000000 (2.0), out_ready=1 -> out_data=1 exactly STAGES cycles after accept, out_tag echoes in_tag=5.
- FLT x=0xBF800000 (-1.0), y=0xC0000000 (-2.0) -> 0. FLT with operands swapped -> 1. FEQ x=0x80000000, y=0x00000000 -> 1.
- FMIN x=0x00000000, y=0x80000000 -> 0x80000000. FMAX with operands swapped -> 0x00000000. op=3'b111 -> out_data=0, out_illegal=1.
- Back-to-back 8 ops with out_ready low for 3 cycles mid-stream -> in_ready drops once 2 entries are held, outputs stable while stalled, all 8 results delivered in order with no loss or duplication.
- Assert rst while 2 ops are in flight -> out_valid=0 immediately (asynchronous), no stale result after release. A new op after release completes normally.
- FCMP_NAN_EN defined: FMIN x=0x7FC00001, y=0x3F800000 -> 0x3F800000, out_nan=1. FEQ x=y=0x7FC00000 -> 0. Without the macro, the same FEQ -> 1 and out_nan=0.
